// File: rtl/mem_access_ctrl_if.sv
// Request/response and MainMemory pin bundle for mem_access_ctrl.
// Statistics counters exist only when MEM_ACCESS_STATS_EN is defined.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_write_enable;
    logic [15:0] mem_data_out;
`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] err_count;
`endif

    // slave: the controller; master: client plus memory side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_addr, mem_data_in, mem_write_enable
`ifdef MEM_ACCESS_STATS_EN
        , output rd_count, wr_count, err_count
`endif
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
               mem_addr, mem_data_in, mem_write_enable
`ifdef MEM_ACCESS_STATS_EN
        , input rd_count, wr_count, err_count
`endif
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding initiator for the MainMemory port: registered pin drive,
// read capture after READ_LATENCY. Optional counters via MEM_ACCESS_STATS_EN.
module mem_access_ctrl #(
    parameter int ADDR_LIMIT   = 16384,
    parameter int READ_LATENCY = 1
) (
    input logic clk,
    input logic reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_t     state;
    logic [2:0] lat_cnt;
    logic       accept;
    logic       in_range;

    assign accept   = bus.req_valid & bus.req_ready;
    assign in_range = ({16'd0, bus.req_addr} < 32'(ADDR_LIMIT));

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt;

    assign bus.rd_count  = rd_cnt;
    assign bus.wr_count  = wr_cnt;
    assign bus.err_count = err_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state                <= IDLE;
            lat_cnt              <= 3'd0;
            bus.req_ready        <= 1'b1;
            bus.rsp_valid        <= 1'b0;
            bus.rsp_err          <= 1'b0;
            bus.rsp_rdata        <= 16'd0;
            bus.mem_addr         <= 16'd0;
            bus.mem_data_in      <= 16'd0;
            bus.mem_write_enable <= 1'b0;
`ifdef MEM_ACCESS_STATS_EN
            rd_cnt  <= 16'd0;
            wr_cnt  <= 16'd0;
            err_cnt <= 16'd0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_range) begin
                            bus.mem_addr         <= bus.req_addr;
                            bus.mem_data_in      <= bus.req_wdata;
                            bus.mem_write_enable <= bus.req_write;
                            bus.req_ready        <= 1'b0;
                            state                <= ISSUE;
                        end else begin
                            // rejected: answer immediately, memory untouched
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
`ifdef MEM_ACCESS_STATS_EN
                            err_cnt <= sat_inc(err_cnt);
`endif
                        end
                    end
                end
                ISSUE: begin
                    // write_enable still holds the captured direction here
                    bus.mem_write_enable <= 1'b0;
                    if (bus.mem_write_enable) begin
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
`ifdef MEM_ACCESS_STATS_EN
                        wr_cnt <= sat_inc(wr_cnt);
`endif
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        bus.rsp_rdata <= bus.mem_data_out;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
`ifdef MEM_ACCESS_STATS_EN
                        rd_cnt <= sat_inc(rd_cnt);
`endif
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                RESP: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: latency-1 and latency-3 controllers, each on a simple
// registered memory model.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus1();
    mem_access_ctrl_if bus2();

    mem_access_ctrl #(.ADDR_LIMIT(16384), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave));
    mem_access_ctrl #(.ADDR_LIMIT(16384), .READ_LATENCY(3)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    logic [15:0] mem1 [0:16383];
    logic [15:0] mem2 [0:16383];
    logic [15:0] p0, p1, p2;

    always @(posedge clk) begin
        if (bus1.mem_write_enable) mem1[bus1.mem_addr[13:0]] <= bus1.mem_data_in;
        bus1.mem_data_out <= mem1[bus1.mem_addr[13:0]];
    end

    // three-cycle read pipeline
    always @(posedge clk) begin
        if (bus2.mem_write_enable) mem2[bus2.mem_addr[13:0]] <= bus2.mem_data_in;
        p0 <= mem2[bus2.mem_addr[13:0]];
        p1 <= p0;
        p2 <= p1;
    end
    assign bus2.mem_data_out = p2;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req1(input logic w, input logic [15:0] a, input logic [15:0] d);
        bus1.req_valid = 1'b1;
        bus1.req_write = w;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
        tick();
        bus1.req_valid = 1'b0;
        bus1.req_addr  = 16'hDEAD;
        bus1.req_wdata = 16'hBEEF;
    endtask

    task automatic do_write1(input logic [15:0] a, input logic [15:0] d);
        req1(1'b1, a, d);
        chk("wr_we_on", {15'd0, bus1.mem_write_enable}, 16'd1);
        chk("wr_addr", bus1.mem_addr, a);
        chk("wr_data", bus1.mem_data_in, d);
        chk("wr_busy", {15'd0, bus1.req_ready}, 16'd0);
        tick();
        chk("wr_we_off", {15'd0, bus1.mem_write_enable}, 16'd0);
        chk("wr_rsp", {15'd0, bus1.rsp_valid}, 16'd1);
        chk("wr_err", {15'd0, bus1.rsp_err}, 16'd0);
        tick();
        chk("wr_rsp_end", {15'd0, bus1.rsp_valid}, 16'd0);
        chk("wr_ready", {15'd0, bus1.req_ready}, 16'd1);
    endtask

    task automatic do_read1(input logic [15:0] a, input logic [15:0] exp);
        req1(1'b0, a, 16'h0);
        chk("rd_busy", {15'd0, bus1.req_ready}, 16'd0);
        chk("rd_we", {15'd0, bus1.mem_write_enable}, 16'd0);
        chk("rd_c1", {15'd0, bus1.rsp_valid}, 16'd0);
        tick();
        chk("rd_c2", {15'd0, bus1.rsp_valid}, 16'd0);
        tick();
        chk("rd_c3", {15'd0, bus1.rsp_valid}, 16'd1);
        chk("rd_err", {15'd0, bus1.rsp_err}, 16'd0);
        chk("rd_data", bus1.rsp_rdata, exp);
        tick();
        chk("rd_rsp_end", {15'd0, bus1.rsp_valid}, 16'd0);
        chk("rd_hold", bus1.rsp_rdata, exp);
        chk("rd_ready", {15'd0, bus1.req_ready}, 16'd1);
    endtask

    initial begin
        int n;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0;
        bus1.req_addr  = 16'h0; bus1.req_wdata = 16'h0;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0;
        bus2.req_addr  = 16'h0; bus2.req_wdata = 16'h0;
        mem2[14'h0020] = 16'h5A5A;
        reset = 1'b0;
        tick(); tick();
        chk("rst_ready", {15'd0, bus1.req_ready}, 16'd1);
        chk("rst_rsp", {15'd0, bus1.rsp_valid}, 16'd0);
        chk("rst_err", {15'd0, bus1.rsp_err}, 16'd0);
        chk("rst_rdata", bus1.rsp_rdata, 16'h0);
        chk("rst_maddr", bus1.mem_addr, 16'h0);
        chk("rst_mdin", bus1.mem_data_in, 16'h0);
        chk("rst_we", {15'd0, bus1.mem_write_enable}, 16'd0);
        reset = 1'b1;
        tick();

        do_write1(16'h0010, 16'h1234);
        do_read1(16'h0010, 16'h1234);

        // out-of-range reads
        req1(1'b0, 16'h4000, 16'h0);
        chk("e1_rsp", {15'd0, bus1.rsp_valid}, 16'd1);
        chk("e1_err", {15'd0, bus1.rsp_err}, 16'd1);
        chk("e1_we", {15'd0, bus1.mem_write_enable}, 16'd0);
        chk("e1_rdata", bus1.rsp_rdata, 16'h1234);
        chk("e1_ready", {15'd0, bus1.req_ready}, 16'd1);
        tick();
        chk("e1_end", {15'd0, bus1.rsp_valid}, 16'd0);
        chk("e1_err_end", {15'd0, bus1.rsp_err}, 16'd0);
        chk("e1_maddr", bus1.mem_addr, 16'h0010);
        req1(1'b1, 16'hFFFF, 16'h5555);
        chk("e2_err", {15'd0, bus1.rsp_err}, 16'd1);
        chk("e2_we", {15'd0, bus1.mem_write_enable}, 16'd0);
        chk("e2_maddr", bus1.mem_addr, 16'h0010);
        tick();

        // back-to-back writes with req_valid held high
        bus1.req_valid = 1'b1;
        bus1.req_write = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus1.req_addr  = 16'(i);
            bus1.req_wdata = 16'(16'h9 + i);
            n = 0;
            while (!bus1.req_ready && n < 10) begin
                tick();
                n++;
            end
            chk("b2b_wait", {15'd0, bus1.req_ready}, 16'd1);
            tick();
            chk("b2b_busy", {15'd0, bus1.req_ready}, 16'd0);
            chk("b2b_we", {15'd0, bus1.mem_write_enable}, 16'd1);
            chk("b2b_addr", bus1.mem_addr, 16'(i));
        end
        bus1.req_valid = 1'b0;
        tick(); tick();
        do_read1(16'h0001, 16'h000A);
        do_read1(16'h0002, 16'h000B);
        do_read1(16'h0003, 16'h000C);

        // latency-3 controller
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b0;
        bus2.req_addr  = 16'h0020;
        tick();
        bus2.req_valid = 1'b0;
        bus2.req_addr  = 16'h0000;
        for (int c = 1; c <= 4; c++) begin
            chk("l3_wait", {15'd0, bus2.rsp_valid}, 16'd0);
            tick();
        end
        chk("l3_rsp", {15'd0, bus2.rsp_valid}, 16'd1);
        chk("l3_data", bus2.rsp_rdata, 16'h5A5A);
        tick();
        chk("l3_end", {15'd0, bus2.rsp_valid}, 16'd0);

        // reset while waiting for read data
        req1(1'b0, 16'h0010, 16'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("rw_rsp", {15'd0, bus1.rsp_valid}, 16'd0);
        chk("rw_ready", {15'd0, bus1.req_ready}, 16'd1);
        chk("rw_rdata", bus1.rsp_rdata, 16'h0);
        reset = 1'b1;
        tick();
        chk("rw_rsp2", {15'd0, bus1.rsp_valid}, 16'd0);
        chk("rw_ready2", {15'd0, bus1.req_ready}, 16'd1);
        do_read1(16'h0010, 16'h1234);

        do_write1(16'h0030, 16'h0777);
        do_read1(16'h0030, 16'h0777);
        req1(1'b0, 16'h8000, 16'h0);
        chk("e3_err", {15'd0, bus1.rsp_err}, 16'd1);
        tick();
`ifdef MEM_ACCESS_STATS_EN
        chk("st_rd", bus1.rd_count, 16'd2);
        chk("st_wr", bus1.wr_count, 16'd1);
        chk("st_err", bus1.err_count, 16'd1);
        force dut1.rd_cnt = 16'hFFFF;
        tick();
        release dut1.rd_cnt;
        do_read1(16'h0030, 16'h0777);
        chk("st_sat", bus1.rd_count, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
